vdm_tx_pkt_fifo: RTL and testbench

VDM_TX_PKT_FIFO -- requirements
Module: vdm_tx_pkt_fifo

---
 rtl/vdm_tx_pkg.sv | 34 +++
 rtl/vdm_tx_word_ram.sv | 37 +++
 rtl/vdm_tx_pkt_fifo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_vdm_tx_pkt_fifo.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdm_tx_pkg.sv
// Shared definitions for the VDM transmit packet FIFO: FCR layout, FSM state types
// and default sizing.
package vdm_tx_pkg;

    localparam int VDM_TX_DEPTH_DEF   = 64;
    localparam int VDM_TX_MAX_PKT_DEF = 16;

    // FCR write bits
    localparam int FCR_COMMIT_BIT = 0;
    localparam int FCR_CLEAR_BIT  = 1;

    // FCR read layout
    localparam int FCR_FREE_LSB   = 0;
    localparam int FCR_CNT_LSB    = 16;
    localparam int FCR_STICKY_BIT = 24;
    localparam int FCR_DROP_LSB   = 25;

    localparam logic [7:0] PKT_CNT_MAX = 8'd255;

    typedef enum logic {
        WR_ACCEPT  = 1'b0,
        WR_DISCARD = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/vdm_tx_word_ram.sv
// Simple dual-port word store: one write port, one read port with a registered,
// enable-held output that directly feeds the stream data output.
module vdm_tx_word_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value when not enabled so stalled data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 32'h0000_0000;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vdm_tx_pkt_fifo.sv
// CSR-fed packet FIFO streaming committed VDM packets to the egress stage.
// Optional macro VDM_TX_DROP_CNT_EN adds a 7-bit dropped-packet count in fcr_rdata[31:25].
module vdm_tx_pkt_fifo
    import vdm_tx_pkg::*;
#(
    parameter int DEPTH         = VDM_TX_DEPTH_DEF,
    parameter int MAX_PKT_WORDS = VDM_TX_MAX_PKT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wr,
    input  logic        csr_sel,
    input  logic [31:0] csr_wdata,
    output logic [31:0] fcr_rdata,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready
);

    localparam int AW       = $clog2(DEPTH);
    localparam int UW       = AW + 1;
    localparam int LEN_W    = $clog2(MAX_PKT_WORDS + 1);
    localparam int LQ_DEPTH = (DEPTH < 256) ? DEPTH : 256;
    localparam int LQW      = $clog2(LQ_DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_WORDS);

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] open_len_q, open_len_d, fetch_left_q, fetch_left_d;
    logic [UW-1:0]    used_q, used_d;
    logic [7:0]       pkt_cnt_q, pkt_cnt_d;
    logic             sticky_q, sticky_d;
    logic             valid_q, valid_d, last_q, last_d;
    logic [31:0]      fcr_q;

    logic [LEN_W-1:0] lq_mem_q [LQ_DEPTH];
    logic [LQW-1:0]   lq_wr_q, lq_rd_q;
    logic [LEN_W-1:0] lq_head_s;

    logic        dr_wr_s, commit_req_s, clear_req_s, store_full_s;
    logic        ram_we_s, ram_re_s, drop_s, commit_s, lq_pop_s;
    logic        xfer_s, load_s, last_xfer_s;
    logic [6:0]  drop_fld_s;
    logic [15:0] free_d_s;
    logic [31:0] ram_rdata_s;

    assign dr_wr_s      = csr_wr & ~csr_sel;
    assign commit_req_s = csr_wr & csr_sel & csr_wdata[FCR_COMMIT_BIT];
    assign clear_req_s  = csr_wr & csr_sel & csr_wdata[FCR_CLEAR_BIT];
    assign store_full_s = (used_q == UW'(DEPTH));
    assign xfer_s       = valid_q & m_tready;
    assign load_s       = ~valid_q | m_tready;
    assign last_xfer_s  = xfer_s & last_q;
    assign lq_head_s    = lq_mem_q[lq_rd_q];

    // Write side: word capture, commit, and drop/rewind handling.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        open_len_d  = open_len_q;
        sticky_d    = sticky_q;
        ram_we_s    = 1'b0;
        drop_s      = 1'b0;
        commit_s    = 1'b0;
        if (dr_wr_s && (wr_state_q == WR_ACCEPT)) begin
            if (store_full_s || (open_len_q == MAX_LEN)) begin
                drop_s     = 1'b1;
                wr_state_d = WR_DISCARD;
            end else begin
                ram_we_s   = 1'b1;
                wr_ptr_d   = wr_ptr_q + AW'(1);
                open_len_d = open_len_q + LEN_W'(1);
            end
        end else if (commit_req_s) begin
            if (wr_state_q == WR_DISCARD) begin
                wr_state_d = WR_ACCEPT;
            end else if (open_len_q == LEN_W'(0)) begin
                wr_state_d = WR_ACCEPT;
            end else if (pkt_cnt_q == PKT_CNT_MAX) begin
                // No room to count another packet: drop it but stay ready for the next one.
                drop_s = 1'b1;
            end else begin
                commit_s    = 1'b1;
                pkt_start_d = wr_ptr_q;
                open_len_d  = LEN_W'(0);
            end
        end else begin
            wr_state_d = wr_state_q;
        end
        if (drop_s) begin
            wr_ptr_d   = pkt_start_q;
            open_len_d = LEN_W'(0);
            sticky_d   = 1'b1;
        end else begin
            sticky_d = sticky_q;
        end
        if (clear_req_s) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_d;
        end
    end

    // Read FSM: prefetches into the output register whenever it is empty or draining.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_ptr_d     = rd_ptr_q;
        fetch_left_d = fetch_left_q;
        valid_d      = valid_q;
        last_d       = last_q;
        ram_re_s     = 1'b0;
        lq_pop_s     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (pkt_cnt_q != 8'd0) begin
                    lq_pop_s     = 1'b1;
                    ram_re_s     = 1'b1;
                    rd_ptr_d     = rd_ptr_q + AW'(1);
                    valid_d      = 1'b1;
                    last_d       = (lq_head_s == LEN_W'(1));
                    fetch_left_d = lq_head_s - LEN_W'(1);
                    rd_state_d   = RD_SEND;
                end else begin
                    valid_d = 1'b0;
                end
            end
            RD_SEND: begin
                if (!load_s) begin
                    valid_d = valid_q;
                end else if (fetch_left_q != LEN_W'(0)) begin
                    ram_re_s     = 1'b1;
                    rd_ptr_d     = rd_ptr_q + AW'(1);
                    valid_d      = 1'b1;
                    last_d       = (fetch_left_q == LEN_W'(1));
                    fetch_left_d = fetch_left_q - LEN_W'(1);
                end else if (pkt_cnt_q > 8'd1) begin
                    // Final word leaving and another packet queued: chain without a gap.
                    lq_pop_s     = 1'b1;
                    ram_re_s     = 1'b1;
                    rd_ptr_d     = rd_ptr_q + AW'(1);
                    valid_d      = 1'b1;
                    last_d       = (lq_head_s == LEN_W'(1));
                    fetch_left_d = lq_head_s - LEN_W'(1);
                end else begin
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: begin
                valid_d    = 1'b0;
                last_d     = 1'b0;
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Occupancy and committed-packet bookkeeping.
    always_comb begin
        used_d = used_q;
        if (ram_we_s) begin
            used_d = used_d + UW'(1);
        end else if (drop_s) begin
            used_d = used_d - UW'(open_len_q);
        end else begin
            used_d = used_q;
        end
        if (xfer_s) begin
            used_d = used_d - UW'(1);
        end else begin
            used_d = used_d;
        end
        if (commit_s && !last_xfer_s) begin
            pkt_cnt_d = pkt_cnt_q + 8'd1;
        end else if (!commit_s && last_xfer_s) begin
            pkt_cnt_d = pkt_cnt_q - 8'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    assign free_d_s = 16'(DEPTH) - 16'(used_d);

`ifdef VDM_TX_DROP_CNT_EN
    logic [6:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_req_s) begin
            drop_cnt_d = 7'd0;
        end else if (drop_s) begin
            drop_cnt_d = sat_inc7(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 7'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_fld_s = drop_cnt_d;
`else
    assign drop_fld_s = 7'd0;
`endif

    // Length queue storage; one entry per committed packet not yet started.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            lq_mem_q[lq_wr_q] <= open_len_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q   <= WR_ACCEPT;
            rd_state_q   <= RD_IDLE;
            wr_ptr_q     <= AW'(0);
            pkt_start_q  <= AW'(0);
            rd_ptr_q     <= AW'(0);
            open_len_q   <= LEN_W'(0);
            fetch_left_q <= LEN_W'(0);
            used_q       <= UW'(0);
            pkt_cnt_q    <= 8'd0;
            sticky_q     <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            lq_wr_q      <= LQW'(0);
            lq_rd_q      <= LQW'(0);
            fcr_q        <= {7'd0, 1'b0, 8'd0, 16'(DEPTH)};
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            wr_ptr_q     <= wr_ptr_d;
            pkt_start_q  <= pkt_start_d;
            rd_ptr_q     <= rd_ptr_d;
            open_len_q   <= open_len_d;
            fetch_left_q <= fetch_left_d;
            used_q       <= used_d;
            pkt_cnt_q    <= pkt_cnt_d;
            sticky_q     <= sticky_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            lq_wr_q      <= commit_s ? lq_wr_q + LQW'(1) : lq_wr_q;
            lq_rd_q      <= lq_pop_s ? lq_rd_q + LQW'(1) : lq_rd_q;
            fcr_q        <= {drop_fld_s, sticky_d, pkt_cnt_d, free_d_s};
        end
    end

    vdm_tx_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_word_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (ram_we_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (csr_wdata),
        .rd_en_i   (ram_re_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata_s)
    );

    assign fcr_rdata = fcr_q;
    assign m_tdata   = ram_rdata_s;
    assign m_tvalid  = valid_q;
    assign m_tlast   = last_q;

endmodule

// File: tb/tb_vdm_tx_pkt_fifo.sv
// Self-checking bench for vdm_tx_pkt_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based packet model.
module tb_vdm_tx_pkt_fifo;

    localparam int DEPTH = 64;
    localparam int MAXW  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_wr;
    logic        csr_sel;
    logic [31:0] csr_wdata;
    logic [31:0] fcr_rdata;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    always #5 clk = ~clk;

    vdm_tx_pkt_fifo #(
        .DEPTH         (DEPTH),
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr_wr    (csr_wr),
        .csr_sel   (csr_sel),
        .csr_wdata (csr_wdata),
        .fcr_rdata (fcr_rdata),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        wr;
        logic        sel;
        logic [31:0] wd;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [15:0] efree;
        logic [7:0]  ecnt;
    } vec_t;

    // Reference model: packets as queues of words.
    beat_t       exp_q[$];
    logic [31:0] open_q[$];
    int          stored;
    int          committed;
    int          drops;
    bit          discard;
    bit          sticky;

    int          checks   = 0;
    int          failures = 0;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        open_q.delete();
        stored     = 0;
        committed  = 0;
        drops      = 0;
        discard    = 1'b0;
        sticky     = 1'b0;
        prev_stall = 1'b0;
    endfunction

    function automatic void model_drop();
        stored -= open_q.size();
        open_q.delete();
        sticky = 1'b1;
        drops  = (drops < 127) ? drops + 1 : 127;
    endfunction

    function automatic void model_csr(input logic wr, input logic sel, input logic [31:0] wd);
        beat_t b;
        if (wr && !sel && !discard) begin
            if (stored == DEPTH || open_q.size() == MAXW) begin
                model_drop();
                discard = 1'b1;
            end else begin
                open_q.push_back(wd);
                stored++;
            end
        end
        if (wr && sel) begin
            if (wd[0]) begin
                if (discard) begin
                    discard = 1'b0;
                end else if (open_q.size() > 0) begin
                    if (committed == 255) begin
                        model_drop();
                    end else begin
                        for (int i = 0; i < open_q.size(); i++) begin
                            b.data = open_q[i];
                            b.last = (i == open_q.size() - 1);
                            exp_q.push_back(b);
                        end
                        committed++;
                        open_q.delete();
                    end
                end
            end
            if (wd[1]) begin
                sticky = 1'b0;
                drops  = 0;
            end
        end
    endfunction

    function automatic logic [31:0] model_fcr();
        logic [6:0] d;
`ifdef VDM_TX_DROP_CNT_EN
        d = 7'(drops);
`else
        d = 7'd0;
`endif
        return {d, sticky, 8'(committed), 16'(DEPTH - stored)};
    endfunction

    // One clock: drive inputs, score any transfer, advance the model, check FCR after the edge.
    task automatic step(input logic wr, input logic sel, input logic [31:0] wd, input logic rdy);
        beat_t e;
        bit    xfer;
        csr_wr    = wr;
        csr_sel   = sel;
        csr_wdata = wd;
        m_tready  = rdy;
        xfer = (m_tvalid === 1'b1) && rdy;
        if (prev_stall) begin
            chk("stall_data", m_tdata, prev_data);
            chk("stall_last", m_tlast, prev_last);
        end
        prev_stall = (m_tvalid === 1'b1) && !rdy;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        model_csr(wr, sel, wd);
        if (xfer) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected actual=0x%08h required=no_beat", m_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_tdata, e.data);
                chk("beat_last", m_tlast, e.last);
                stored--;
                if (e.last) committed--;
            end
        end
        @(posedge clk);
        #1;
        csr_wr = 1'b0;
        chk("fcr", fcr_rdata, model_fcr());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || m_tvalid) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, exp_q.size());
        end
    endtask

    vec_t vt[10];

    initial begin
        int          r;
        int          n;
        int          nx;
        logic        rdy;
        logic [31:0] wd;

        rst_n     = 1'b0;
        csr_wr    = 1'b0;
        csr_sel   = 1'b0;
        csr_wdata = 32'h0;
        m_tready  = 1'b0;
        model_reset();

        // Single 4-word packet, ready held high: {inputs, post-edge expectations}.
        vt[0] = '{1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 32'h0,  1'b0, 16'd63, 8'd0};
        vt[1] = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b0, 32'h0,  1'b0, 16'd62, 8'd0};
        vt[2] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 32'h0,  1'b0, 16'd61, 8'd0};
        vt[3] = '{1'b1, 1'b0, 32'hA3, 1'b1, 1'b0, 32'h0,  1'b0, 16'd60, 8'd0};
        vt[4] = '{1'b1, 1'b1, 32'h1,  1'b1, 1'b0, 32'h0,  1'b0, 16'd60, 8'd1};
        vt[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA0, 1'b0, 16'd60, 8'd1};
        vt[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b0, 16'd61, 8'd1};
        vt[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA2, 1'b0, 16'd62, 8'd1};
        vt[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA3, 1'b1, 16'd63, 8'd1};
        vt[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 16'd64, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", m_tvalid, 1'b0);
        chk("reset_last", m_tlast, 1'b0);
        chk("reset_data", m_tdata, 32'h0);
        chk("reset_fcr", fcr_rdata, 32'h0000_0040);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) begin
            step(vt[k].wr, vt[k].sel, vt[k].wd, vt[k].rdy);
            chk($sformatf("vec%0d_valid", k), m_tvalid, vt[k].ev);
            if (vt[k].ev) begin
                chk($sformatf("vec%0d_data", k), m_tdata, vt[k].ed);
                chk($sformatf("vec%0d_last", k), m_tlast, vt[k].el);
            end
            chk($sformatf("vec%0d_free", k), fcr_rdata[15:0], vt[k].efree);
            chk($sformatf("vec%0d_cnt", k), fcr_rdata[23:16], vt[k].ecnt);
        end

        // Two 3-word packets back to back.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hB0 + i, 1'b0);
        step(1'b1, 1'b1, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0 + i, 1'b0);
        step(1'b1, 1'b1, 32'h1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("b2b_valid", m_tvalid, 1'b1);
            chk("b2b_last", m_tlast, (i == 2 || i == 5));
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("b2b_after", m_tvalid, 1'b0);

        // Oversize packet is dropped; following packet intact.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 32'hD00 + i, 1'b1);
        chk("drop_sticky", fcr_rdata[24], 1'b1);
        step(1'b1, 1'b1, 32'h1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drop_no_emit", m_tvalid, 1'b0);
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        step(1'b1, 1'b0, 32'hE0, 1'b1);
        step(1'b1, 1'b0, 32'hE1, 1'b1);
        step(1'b1, 1'b1, 32'h1, 1'b1);
        drain("drop_next");
`ifdef VDM_TX_DROP_CNT_EN
        chk("drop_count", fcr_rdata[31:25], 7'd1);
`else
        chk("drop_count", fcr_rdata[31:25], 7'd0);
`endif
        step(1'b1, 1'b1, 32'h2, 1'b1);
        chk("sticky_clear", fcr_rdata[24], 1'b0);

        // Ready toggling every cycle over a 5-word packet.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hF0 + i, 1'b0);
        step(1'b1, 1'b1, 32'h1, 1'b0);
        nx = 0;
        n  = 0;
        while (nx < 5 && n < 40) begin
            rdy = n[0];
            if (m_tvalid && rdy) nx++;
            step(1'b0, 1'b0, 32'h0, rdy);
            n++;
        end
        chk("toggle_beats", nx, 5);
        chk("toggle_idle", m_tvalid, 1'b0);

        // Reset in the middle of a stalled packet plus a half-written one.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h580 + i, 1'b0);
        step(1'b1, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h5A0, 1'b0);
        step(1'b1, 1'b0, 32'h5A1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", m_tvalid, 1'b0);
        chk("midrst_last", m_tlast, 1'b0);
        chk("midrst_data", m_tdata, 32'h0);
        chk("midrst_fcr", fcr_rdata, 32'h0000_0040);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h600 + i, 1'b1);
        step(1'b1, 1'b1, 32'h1, 1'b1);
        drain("after_reset");

        // Commit in the same cycle as the final-word transfer.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h700 + i, 1'b0);
        step(1'b1, 1'b1, 32'h1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h710 + i, 1'b0);
        n = 0;
        while (!(m_tvalid && m_tlast) && n < 50) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("same_cycle_last_seen", m_tvalid && m_tlast, 1'b1);
        step(1'b1, 1'b1, 32'h1, 1'b1);
        chk("same_cycle_cnt", fcr_rdata[23:16], 8'd1);
        drain("same_cycle");

        // Random traffic: mostly-ready, then mostly-stalled to reach store-full drops.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1200; i++) begin
                r   = $urandom_range(0, 99);
                rdy = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                if (r < 60) begin
                    step(1'b1, 1'b0, $urandom, rdy);
                end else if (r < 70) begin
                    wd = ($urandom & 32'hFFFF_FFFC) | {30'd0, ($urandom_range(0, 7) == 0), 1'b1};
                    step(1'b1, 1'b1, wd, rdy);
                end else if (r < 72) begin
                    wd = ($urandom & 32'hFFFF_FFFC) | 32'h2;
                    step(1'b1, 1'b1, wd, rdy);
                end else begin
                    step(1'b0, 1'b0, 32'h0, rdy);
                end
            end
            step(1'b1, 1'b1, 32'h1, 1'b1);
            drain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
